// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, memory access sizes and LSU FSM states for the memory stage.
package mem_stage_pkg;
  localparam int WORD_WIDTH = 32;
  localparam int REG_ADDR_W = 5;
  typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10} mem_size_t;
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RVALID} lsu_state_t;
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory req/gnt/rvalid bus between the memory stage (master) and memory (slave).
interface mem_stage_if;
  logic                                 req;
  logic                                 gnt;
  logic [mem_stage_pkg::WORD_WIDTH-1:0] addr;
  logic                                 we;
  logic [3:0]                           be;
  logic [mem_stage_pkg::WORD_WIDTH-1:0] wdata;
  logic                                 rvalid;
  logic [mem_stage_pkg::WORD_WIDTH-1:0] rdata;
  logic                                 err;
  modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata, err);
  modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/mem_stage_align.sv
// mem_stage_align: byte enables, lane-replicated store data, alignment check and load extraction.
module mem_stage_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  off_i,
  input  mem_size_t   size_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        aligned_o,
  input  logic [1:0]  ld_off_i,
  input  mem_size_t   ld_size_i,
  input  logic        ld_uns_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ldata_o
);
  logic [31:0] shifted;
  always_comb begin
    be_o      = size_i == SZ_B ? 4'b0001 << off_i : size_i == SZ_H ? 4'b0011 << off_i : 4'b1111;
    wdata_o   = size_i == SZ_B ? {4{wdata_i[7:0]}} : size_i == SZ_H ? {2{wdata_i[15:0]}} : wdata_i;
    aligned_o = size_i == SZ_B ? 1'b1 : size_i == SZ_H ? !off_i[0] : off_i == 2'b00;
    shifted   = rdata_i >> {ld_off_i, 3'b000};
    ldata_o   = ld_size_i == SZ_B ? {{24{!ld_uns_i & shifted[7]}}, shifted[7:0]} :
                ld_size_i == SZ_H ? {{16{!ld_uns_i & shifted[15]}}, shifted[15:0]} : shifted;
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: load/store FSM on the data bus plus a registered writeback record per retired instruction.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int WORD_WIDTH = mem_stage_pkg::WORD_WIDTH,
  parameter int REG_ADDR_W = mem_stage_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid_i,
  input  logic [WORD_WIDTH-1:0] ex_data_i,
  input  logic [WORD_WIDTH-1:0] rdata2_store_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic                  rf_we_i,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [1:0]            mem_size_i,
  input  logic                  mem_unsigned_i,
  output logic                  stall_o,
  output logic                  wb_valid_o,
  output logic [WORD_WIDTH-1:0] wb_data_o,
  output logic [REG_ADDR_W-1:0] wb_rd_addr_o,
  output logic                  wb_rf_we_o,
  output logic                  misaligned_o,
  output logic                  bus_err_o,
  mem_stage_if.master           bus
);
  lsu_state_t            state_q, state_d;
  logic [WORD_WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, wb_data_q, wb_data_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d, wb_rd_q, wb_rd_d;
  mem_size_t             size_q, size_d;
  logic [3:0]            be_q, be_d;
  logic                  we_q, we_d, uns_q, uns_d, rf_we_q, rf_we_d;
  logic                  wb_valid_q, wb_valid_d, wb_we_q, wb_we_d, mis_q, mis_d, err_q, err_d;
  logic [3:0]            be;
  logic [WORD_WIDTH-1:0] wdata, ldata;
  logic                  aligned;
  mem_stage_align u_align (
    .off_i     (ex_data_i[1:0]),
    .size_i    (mem_size_t'(mem_size_i)),
    .wdata_i   (rdata2_store_i),
    .be_o      (be),
    .wdata_o   (wdata),
    .aligned_o (aligned),
    .ld_off_i  (addr_q[1:0]),
    .ld_size_i (size_q),
    .ld_uns_i  (uns_q),
    .rdata_i   (bus.rdata),
    .ldata_o   (ldata)
  );
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    size_d     = size_q;
    be_d       = be_q;
    we_d       = we_q;
    uns_d      = uns_q;
    rf_we_d    = rf_we_q;
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    wb_we_d    = wb_we_q;
    mis_d      = 1'b0;
    err_d      = 1'b0;
    if (state_q == IDLE && ex_valid_i) begin
      if (!mem_req_i) begin
        wb_valid_d = 1'b1;
        wb_data_d  = ex_data_i;
        wb_rd_d    = rd_addr_i;
        wb_we_d    = rf_we_i;
      end else if (!aligned) begin
        mis_d = 1'b1;
      end else begin
        state_d = REQ;
        addr_d  = ex_data_i;
        wdata_d = wdata;
        rd_d    = rd_addr_i;
        size_d  = mem_size_t'(mem_size_i);
        be_d    = be;
        we_d    = mem_we_i;
        uns_d   = mem_unsigned_i;
        rf_we_d = rf_we_i;
      end
    end
    if (state_q == REQ && bus.gnt) state_d = WAIT_RVALID;
    // Stores and errored loads retire with a zero value and no register write.
    if (state_q == WAIT_RVALID && bus.rvalid) begin
      state_d    = IDLE;
      wb_valid_d = 1'b1;
      wb_data_d  = (bus.err || we_q) ? '0 : ldata;
      wb_rd_d    = rd_q;
      wb_we_d    = rf_we_q & !we_q & !bus.err;
      err_d      = bus.err;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      size_q     <= SZ_B;
      be_q       <= '0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      rf_we_q    <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_we_q    <= 1'b0;
      mis_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      size_q     <= size_d;
      be_q       <= be_d;
      we_q       <= we_d;
      uns_q      <= uns_d;
      rf_we_q    <= rf_we_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      wb_we_q    <= wb_we_d;
      mis_q      <= mis_d;
      err_q      <= err_d;
    end
  end
  assign stall_o      = state_q != IDLE;
  assign wb_valid_o   = wb_valid_q;
  assign wb_data_o    = wb_data_q;
  assign wb_rd_addr_o = wb_rd_q;
  assign wb_rf_we_o   = wb_we_q;
  assign misaligned_o = mis_q;
  assign bus_err_o    = err_q;
  assign bus.req      = state_q == REQ;
  assign bus.addr     = {addr_q[WORD_WIDTH-1:2], 2'b00};
  assign bus.we       = we_q;
  assign bus.be       = be_q;
  assign bus.wdata    = wdata_q;
endmodule
